// File: rtl/display_scan_controller_if.sv
// Handshake and display bus of the 7-segment scan controller.
// The master side supplies digits and brightness; the slave side drives the digit enables.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load_valid;
    logic                    load_ready;
    logic [3:0]              brightness;
    logic [3:0]              digit_value;
    logic [NUM_DIGITS-1:0]   transistor;
    logic                    frame_done;

    modport master (
        output digits_in, load_valid, brightness,
        input  load_ready, digit_value, transistor, frame_done
    );

    modport slave (
        input  digits_in, load_valid, brightness,
        output load_ready, digit_value, transistor, frame_done
    );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan: blank gap, then a duty-limited ACTIVE phase per digit slot.
// New digits are double-buffered and only reach the display at the frame wrap.
module display_scan_controller #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  scanBus
);
    localparam int SLOT_W     = $clog2(NUM_DIGITS);
    localparam int ON_W       = CNT_W + 1;
    localparam int DWELL_UNIT = DWELL_CYCLES / 16;

    typedef enum logic {
        BLANK,
        ACTIVE
    } scanState_t;

    scanState_t                  state_q, state_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ON_W-1:0]             onCycles_q, onCycles_d;
    logic [NUM_DIGITS-1:0][3:0]  display_q, display_d;
    logic [NUM_DIGITS-1:0][3:0]  pending_q, pending_d;
    logic                        pendFull_q, pendFull_d;
    logic                        frameDone_q, frameDone_d;

    logic                        blankLast;
    logic                        dwellLast;
    logic                        lastSlot;
    logic                        loadFire;
    logic [NUM_DIGITS-1:0]       enables;

    assign blankLast = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign dwellLast = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    assign lastSlot  = (slot_q == SLOT_W'(NUM_DIGITS - 1));
    assign loadFire  = scanBus.load_valid && !pendFull_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            slot_q      <= '0;
            cnt_q       <= '0;
            onCycles_q  <= '0;
            display_q   <= '0;
            pending_q   <= '0;
            pendFull_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            onCycles_q  <= onCycles_d;
            display_q   <= display_d;
            pending_q   <= pending_d;
            pendFull_q  <= pendFull_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Brightness is sampled once per slot so the duty cannot change while a digit is lit.
    // The wrap looks at the old pending flag, so a load landing on the wrap edge waits a frame.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q + CNT_W'(1);
        onCycles_d  = onCycles_q;
        display_d   = display_q;
        pending_d   = pending_q;
        pendFull_d  = pendFull_q;
        frameDone_d = 1'b0;

        case (state_q)
            BLANK: begin
                if (blankLast) begin
                    state_d    = ACTIVE;
                    cnt_d      = '0;
                    onCycles_d = ON_W'((32'(scanBus.brightness) + 32'd1) * DWELL_UNIT);
                end
            end
            ACTIVE: begin
                if (dwellLast) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (lastSlot) begin
                        slot_d      = '0;
                        frameDone_d = 1'b1;
                        if (pendFull_q) begin
                            display_d  = pending_q;
                            pendFull_d = 1'b0;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        if (loadFire) begin
            pending_d  = scanBus.digits_in;
            pendFull_d = 1'b1;
        end
    end

    always_comb begin
        enables = '0;
        if (state_q == ACTIVE && {1'b0, cnt_q} < onCycles_q) begin
            enables[slot_q] = 1'b1;
        end
    end

    assign scanBus.transistor  = enables;
    assign scanBus.digit_value = display_q[slot_q];
    assign scanBus.load_ready  = !pendFull_q;
    assign scanBus.frame_done  = frameDone_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a 2-cycle blank, 16-cycle dwell, 2 digits.
// Cycle numbers count clock edges since the last reset release (slot 18 cycles, frame 36).
module tb_display_scan_controller;
    logic clk;
    logic reset;
    int   cycle;
    int   checkCount;
    int   failCount;

    display_scan_controller_if #(.NUM_DIGITS(2)) scanIf ();

    display_scan_controller #(
        .NUM_DIGITS   (2),
        .DWELL_CYCLES (16),
        .BLANK_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scanBus (scanIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic runTo(input int target);
        while (cycle < target) stepCycle();
    endtask

    task automatic applyStimulus(input logic [7:0] digits);
        scanIf.digits_in  = digits;
        scanIf.load_valid = 1'b1;
        stepCycle();
        scanIf.load_valid = 1'b0;
    endtask

    // Walks one whole frame from its first cycle with brightness held constant.
    task automatic checkFrame(input int bright, input logic [3:0] d0, input logic [3:0] d1);
        for (int p = 0; p < 36; p++) begin
            int q;
            int s;
            logic [1:0] expTr;
            s = p / 18;
            q = p % 18;
            expTr = 2'b00;
            if (q >= 2 && (q - 2) < bright + 1) expTr = (s == 0) ? 2'b01 : 2'b10;
            checkOutput("frameTransistor", 32'(scanIf.transistor), 32'(expTr));
            checkOutput("frameDigit", 32'(scanIf.digit_value), 32'((s == 0) ? d0 : d1));
            checkOutput("frameDone", 32'(scanIf.frame_done), 32'(p == 0));
            stepCycle();
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        cycle      = 0;
        reset      = 1'b1;
        scanIf.digits_in  = '0;
        scanIf.load_valid = 1'b0;
        scanIf.brightness = 4'd15;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetTransistor", 32'(scanIf.transistor), 32'h0);
        checkOutput("resetLoadReady", 32'(scanIf.load_ready), 32'h1);
        checkOutput("resetFrameDone", 32'(scanIf.frame_done), 32'h0);
        checkOutput("resetDigit", 32'(scanIf.digit_value), 32'h0);
        reset = 1'b0;
        cycle = 0;

        applyStimulus(8'h5A);
        checkOutput("loadReadyDrop", 32'(scanIf.load_ready), 32'h0);
        checkOutput("blankCycle1", 32'(scanIf.transistor), 32'h0);
        stepCycle();
        checkOutput("firstEnable", 32'(scanIf.transistor), 32'h1);
        checkOutput("displayHeld", 32'(scanIf.digit_value), 32'h0);
        runTo(35);
        checkOutput("noEarlyFrameDone", 32'(scanIf.frame_done), 32'h0);
        checkOutput("noEarlyDisplay", 32'(scanIf.digit_value), 32'h0);
        runTo(36);
        checkOutput("wrapLoadReady", 32'(scanIf.load_ready), 32'h1);

        checkFrame(15, 4'hA, 4'h5);
        scanIf.brightness = 4'd0;
        checkFrame(0, 4'hA, 4'h5);
        scanIf.brightness = 4'd7;
        checkFrame(7, 4'hA, 4'h5);

        runTo(149);
        scanIf.brightness = 4'd0;
        runTo(153);
        checkOutput("midChangeStillOn", 32'(scanIf.transistor), 32'h1);
        runTo(154);
        checkOutput("midChangeOff", 32'(scanIf.transistor), 32'h0);
        runTo(164);
        checkOutput("newDutySlot1On", 32'(scanIf.transistor), 32'h2);
        runTo(165);
        checkOutput("newDutySlot1Off", 32'(scanIf.transistor), 32'h0);

        runTo(180);
        checkOutput("frame5Done", 32'(scanIf.frame_done), 32'h1);
        scanIf.brightness = 4'd15;
        runTo(190);
        applyStimulus(8'h3C);
        checkOutput("midLoadReady", 32'(scanIf.load_ready), 32'h0);
        checkOutput("midLoadDigit0", 32'(scanIf.digit_value), 32'hA);
        runTo(210);
        checkOutput("midLoadSlot1", 32'(scanIf.transistor), 32'h2);
        checkOutput("midLoadDigit1", 32'(scanIf.digit_value), 32'h5);
        runTo(215);
        checkOutput("preWrapReady", 32'(scanIf.load_ready), 32'h0);
        runTo(216);
        checkOutput("wrap3CDone", 32'(scanIf.frame_done), 32'h1);
        checkOutput("wrap3CDigit", 32'(scanIf.digit_value), 32'hC);
        checkOutput("wrap3CReady", 32'(scanIf.load_ready), 32'h1);
        checkOutput("wrap3CBlank", 32'(scanIf.transistor), 32'h0);

        applyStimulus(8'h11);
        checkOutput("load11Ready", 32'(scanIf.load_ready), 32'h0);
        scanIf.digits_in  = 8'h22;
        scanIf.load_valid = 1'b1;
        runTo(220);
        scanIf.load_valid = 1'b0;
        checkOutput("ignoredLoadReady", 32'(scanIf.load_ready), 32'h0);
        runTo(236);
        checkOutput("slot1Digit3", 32'(scanIf.digit_value), 32'h3);
        runTo(252);
        checkOutput("wrap11Done", 32'(scanIf.frame_done), 32'h1);
        checkOutput("wrap11Digit", 32'(scanIf.digit_value), 32'h1);
        checkOutput("wrap11Ready", 32'(scanIf.load_ready), 32'h1);
        runTo(270);
        checkOutput("ignored22Slot1", 32'(scanIf.digit_value), 32'h1);

        runTo(287);
        applyStimulus(8'h44);
        checkOutput("wrapEdgeDone", 32'(scanIf.frame_done), 32'h1);
        checkOutput("wrapEdgeDigit", 32'(scanIf.digit_value), 32'h1);
        checkOutput("wrapEdgeReady", 32'(scanIf.load_ready), 32'h0);
        runTo(306);
        checkOutput("wrapEdgeSlot1", 32'(scanIf.digit_value), 32'h1);
        runTo(324);
        checkOutput("wrap44Done", 32'(scanIf.frame_done), 32'h1);
        checkOutput("wrap44Digit", 32'(scanIf.digit_value), 32'h4);
        checkOutput("wrap44Ready", 32'(scanIf.load_ready), 32'h1);

        runTo(325);
        applyStimulus(8'h77);
        checkOutput("load77Ready", 32'(scanIf.load_ready), 32'h0);
        runTo(345);
        checkOutput("preResetSlot1", 32'(scanIf.transistor), 32'h2);
        reset = 1'b1;
        stepCycle();
        checkOutput("midResetTransistor", 32'(scanIf.transistor), 32'h0);
        checkOutput("midResetReady", 32'(scanIf.load_ready), 32'h1);
        checkOutput("midResetDigit", 32'(scanIf.digit_value), 32'h0);
        checkOutput("midResetFrameDone", 32'(scanIf.frame_done), 32'h0);
        reset = 1'b0;
        cycle = 0;
        runTo(2);
        checkOutput("restartEnable", 32'(scanIf.transistor), 32'h1);
        runTo(36);
        checkOutput("restartFrameDone", 32'(scanIf.frame_done), 32'h1);
        checkOutput("pendingCleared", 32'(scanIf.digit_value), 32'h0);
        checkOutput("restartReady", 32'(scanIf.load_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
